// File: rtl/key_expansion_param.sv
// Iterative AES key schedule (AES-128/192/256 selected per job): one schedule word per clock,
// words kept in an internal store and read back as 128-bit round keys through a registered port.
module key_expansion_param #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         rk_valid
);

  localparam int NR_MAX = MAX_KEY_BITS / 32 + 6;
  localparam int DEPTH  = 4 * (NR_MAX + 1);
  localparam int IW     = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      p = p ^ (b[n] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t         state_q, state_d;
  logic [IW-1:0]  i_q, i_d;
  logic [2:0]     k_q, k_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     nk_q, nk_d;
  logic [3:0]     nr_q, nr_d;
  logic [31:0]    win_q [8];
  logic [31:0]    win_d [8];
  logic [31:0]    mem_q [DEPTH];
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [127:0]   rk_data_q, rk_data_d;
  logic           rk_valid_q, rk_valid_d;

  logic [31:0]    key_words_s [8];
  logic [3:0]     nk_sel_s, nr_sel_s;
  int             key_bits_s;
  logic           legal_s, load_s, wr_en_s;
  logic [31:0]    prev_s, old_s, sw_in_s, sw_out_s, t_s, new_w_s;
  logic [IW-1:0]  last_idx_s, rk_base_s;

  // Key word split and key-size decode.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      key_words_s[3'(j)] = key_in[255 - 32 * j -: 32];
    end
    case (key_size)
      2'b00:   begin nk_sel_s = 4'd4; nr_sel_s = 4'd10; key_bits_s = 32'sd128; end
      2'b01:   begin nk_sel_s = 4'd6; nr_sel_s = 4'd12; key_bits_s = 32'sd192; end
      2'b10:   begin nk_sel_s = 4'd8; nr_sel_s = 4'd14; key_bits_s = 32'sd256; end
      default: begin nk_sel_s = 4'd4; nr_sel_s = 4'd10; key_bits_s = 32'sd0;   end
    endcase
    legal_s = (key_size != 2'b11) && (key_bits_s <= MAX_KEY_BITS);
  end

  // Next schedule word; win_q[0] is w[i-1], win_q[Nk-1] is w[i-Nk]. One shared S-box row.
  always_comb begin
    prev_s     = win_q[0];
    old_s      = win_q[3'(nk_q - 4'd1)];
    sw_in_s    = (k_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
    sw_out_s   = sub_word(sw_in_s);
    if (k_q == 3'd0) begin
      t_s = sw_out_s ^ {rcon_q, 24'h000000};
    end else if ((nk_q == 4'd8) && (k_q == 3'd4)) begin
      t_s = sw_out_s;
    end else begin
      t_s = prev_s;
    end
    new_w_s    = old_s ^ t_s;
    last_idx_s = IW'({nr_q, 2'b11});
  end

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    rcon_d  = rcon_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    win_d   = win_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load_s  = 1'b0;
    wr_en_s = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (start && legal_s) begin
          load_s  = 1'b1;
          state_d = EXPAND;
          i_d     = IW'(nk_sel_s);
          k_d     = 3'd0;
          rcon_d  = 8'h01;
          nk_d    = nk_sel_s;
          nr_d    = nr_sel_s;
          for (int j = 0; j < 8; j++) begin
            win_d[3'(j)] = (j < int'(nk_sel_s)) ? key_words_s[3'(int'(nk_sel_s) - 1 - j)] : 32'h0;
          end
        end else if (start) begin
          err_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      EXPAND: begin
        wr_en_s  = 1'b1;
        win_d[0] = new_w_s;
        for (int j = 1; j < 8; j++) begin
          win_d[3'(j)] = win_q[3'(j - 1)];
        end
        i_d    = i_q + IW'(1);
        k_d    = (k_q == 3'(nk_q - 4'd1)) ? 3'd0 : k_q + 3'd1;
        rcon_d = (k_q == 3'd0) ? xtime(rcon_q) : rcon_q;
        if (i_q == last_idx_s) begin
          state_d = READY;
          done_d  = 1'b1;
        end else begin
          state_d = EXPAND;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == EXPAND);
  end

  // Round-key read; an accepted restart from READY invalidates the port at once.
  always_comb begin
    rk_base_s  = IW'({rk_addr, 2'b00});
    if (rk_addr <= 4'(NR_MAX)) begin
      rk_data_d = {mem_q[rk_base_s], mem_q[rk_base_s + IW'(1)],
                   mem_q[rk_base_s + IW'(2)], mem_q[rk_base_s + IW'(3)]};
    end else begin
      rk_data_d = 128'd0;
    end
    rk_valid_d = (state_q == READY) && !(start && legal_s) && (rk_addr <= nr_q);
  end

  // State, schedule store and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      k_q        <= 3'd0;
      rcon_q     <= 8'h01;
      nk_q       <= 4'd4;
      nr_q       <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rk_data_q  <= 128'd0;
      rk_valid_q <= 1'b0;
      for (int j = 0; j < 8; j++) win_q[3'(j)] <= 32'h0;
      for (int j = 0; j < DEPTH; j++) mem_q[IW'(j)] <= 32'h0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      k_q        <= k_d;
      rcon_q     <= rcon_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rk_data_q  <= rk_data_d;
      rk_valid_q <= rk_valid_d;
      win_q      <= win_d;
      if (load_s) begin
        for (int j = 0; j < 8; j++) begin
          if (j < int'(nk_sel_s)) mem_q[IW'(j)] <= key_words_s[3'(j)];
        end
      end else if (wr_en_s) begin
        mem_q[i_q] <= new_w_s;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign num_rounds = nr_q;
  assign rk_data    = rk_data_q;
  assign rk_valid   = rk_valid_q;

endmodule

// File: tb/tb_key_expansion_param.sv
// Scoreboard bench for key_expansion_param: the driver queues expected pulses and port values,
// a negedge monitor compares them against a FIPS-197 schedule model built from plain arithmetic.
module tb_key_expansion_param;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, start2 = 1'b0;
  logic [1:0]   key_size = 2'd0, key_size2 = 2'd0;
  logic [255:0] key_in = '0;
  logic [3:0]   rk_addr = 4'd0;
  logic         busy, done, err, rk_valid;
  logic [3:0]   num_rounds;
  logic [127:0] rk_data;
  logic         busy2, done2, err2, rk_valid2;
  logic [3:0]   num_rounds2;
  logic [127:0] rk_data2;

  key_expansion_param #(.MAX_KEY_BITS(256)) dut (
    .clock(clock), .reset(reset), .start(start), .key_size(key_size), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .num_rounds(num_rounds),
    .rk_addr(rk_addr), .rk_data(rk_data), .rk_valid(rk_valid));

  key_expansion_param #(.MAX_KEY_BITS(128)) dut128 (
    .clock(clock), .reset(reset), .start(start2), .key_size(key_size2), .key_in(key_in),
    .busy(busy2), .done(done2), .err(err2), .num_rounds(num_rounds2),
    .rk_addr(rk_addr), .rk_data(rk_data2), .rk_valid(rk_valid2));

  always #5 clock = ~clock;

  typedef struct { int due; int kind; } ev_t;               // kind 0 = done, 1 = err
  typedef struct { int due; int what; logic [128:0] exp; } chk_t;
  // what: 0 round key, 1 busy, 2 num_rounds, 3 err of 128-bit instance, 4 round key port all-zero

  ev_t        ev_q[$];
  chk_t       chk_q[$];
  int         cyc = 0, n_cmp = 0, n_fail = 0;
  bit [7:0]   sb [256];
  bit [31:0]  ref_w [60];
  ev_t        mon_e;
  chk_t       mon_c;
  logic [128:0] mon_act;
  bit         mon_ok;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic bit [7:0] gm(bit [7:0] a, bit [7:0] b);
    bit [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic bit [31:0] subw(bit [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_ref(input logic [255:0] k, input int ks);
    int nk = 4 + 2 * ks;
    int total = 4 * (nk + 7);
    bit [7:0] rc = 8'h01;
    bit [31:0] t;
    for (int i = 0; i < nk; i++) ref_w[i] = k[255 - 32 * i -: 32];
    for (int i = nk; i < total; i++) begin
      t = ref_w[i - 1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      ref_w[i] = ref_w[i - nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk_of(int r);
    return {ref_w[4 * r], ref_w[4 * r + 1], ref_w[4 * r + 2], ref_w[4 * r + 3]};
  endfunction

  // Monitor: pulses pop the event queue, scheduled port checks fire on their due cycle.
  always @(negedge clock) begin
    if (done || err) begin
      n_cmp++;
      if (ev_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse: unexpected done=%0b err=%0b at cycle %0d, required none", done, err, cyc);
      end else begin
        mon_e = ev_q.pop_front();
        if ((done && err) || mon_e.kind != (err ? 1 : 0) || mon_e.due != cyc) begin
          n_fail++;
          $display("FAIL pulse: got done=%0b err=%0b at cycle %0d, required kind %0d at cycle %0d",
                   done, err, cyc, mon_e.kind, mon_e.due);
        end
      end
    end else if (ev_q.size() != 0 && ev_q[0].due < cyc) begin
      n_cmp++;
      n_fail++;
      mon_e = ev_q.pop_front();
      $display("FAIL pulse: none by cycle %0d, required kind %0d at cycle %0d", cyc, mon_e.kind, mon_e.due);
    end
    for (int n = chk_q.size() - 1; n >= 0; n--) begin
      if (chk_q[n].due == cyc) begin
        mon_c = chk_q[n];
        chk_q.delete(n);
        case (mon_c.what)
          0:       mon_act = {rk_valid, rk_data};
          1:       mon_act = {128'd0, busy};
          2:       mon_act = {125'd0, num_rounds};
          3:       mon_act = {128'd0, err2};
          default: mon_act = {rk_valid, rk_data};
        endcase
        if (mon_c.what == 0 && mon_c.exp[128] == 1'b0) mon_ok = (rk_valid === 1'b0);
        else mon_ok = (mon_act === mon_c.exp);
        n_cmp++;
        if (!mon_ok) begin
          n_fail++;
          $display("FAIL port%0d cycle %0d: got %h, required %h", mon_c.what, cyc, mon_act, mon_c.exp);
        end
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic push_chk(input int what, input logic [128:0] exp);
    chk_q.push_back('{due: cyc + 1, what: what, exp: exp});
  endtask

  task automatic start_job(input logic [255:0] k, input int ks);
    int nk = 4 + 2 * ks;
    int nr = nk + 6;
    build_ref(k, ks);
    key_in = k;
    key_size = 2'(ks);
    start = 1'b1;
    ev_q.push_back('{cyc + 1 + 4 * (nr + 1) - nk, 0});
    push_chk(1, 129'd1);
    push_chk(2, 129'(nr));
    step;
    start = 1'b0;
  endtask

  task automatic wait_events;
    for (int n = 0; n < 64 && ev_q.size() != 0; n++) step;
    step;
  endtask

  task automatic sweep(input int nr);
    for (int r = 0; r <= nr + 1; r++) begin
      rk_addr = 4'(r);
      push_chk(0, (r <= nr) ? {1'b1, rk_of(r)} : 129'd0);
      step;
    end
    step;
  endtask

  task automatic spec_rk(input int r, input logic [127:0] v);
    rk_addr = 4'(r);
    push_chk(0, {1'b1, v});
    step;
  endtask

  task automatic illegal_start;
    key_size = 2'b11;
    start = 1'b1;
    ev_q.push_back('{cyc + 1, 1});
    push_chk(1, 129'd0);
    push_chk(0, {1'b1, rk_of(int'(rk_addr))});
    step;
    start = 1'b0;
    push_chk(0, {1'b1, rk_of(int'(rk_addr))});
    step;
  endtask

  logic [255:0] k1, k2, k3, kr;
  int ks;

  initial begin
    bit [7:0] inv, s, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sb[a] = s;
    end
    k1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    step; step;
    push_chk(1, 129'd0);
    push_chk(2, 129'd0);
    push_chk(4, 129'd0);
    step;
    reset = 1'b0;
    step;

    start_job(k1, 0); wait_events;
    spec_rk(1, 128'ha0fafe1788542cb123a339392a6c7605);
    spec_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep(10);
    rk_addr = 4'd10;
    illegal_start;

    start_job(k2, 1); wait_events;
    spec_rk(12, 128'he98ba06f448c773c8ecc720401002202);
    sweep(12);

    start_job(k3, 2); wait_events;
    spec_rk(14, 128'hfe4890d1e6188d0b046df344706c631e);
    sweep(14);

    start_job(k1, 0);
    repeat (4) step;
    key_in = {8{$urandom}};
    key_size = 2'b10;
    start = 1'b1;
    step;
    start = 1'b0;
    wait_events;
    sweep(10);

    start_job(k1, 0);
    repeat (19) step;
    reset = 1'b1;
    ev_q.delete();
    push_chk(1, 129'd0);
    push_chk(0, 129'd0);
    step;
    reset = 1'b0;
    repeat (50) step;
    start_job(k1, 0); wait_events;
    spec_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep(10);

    for (int n = 0; n < 6; n++) begin
      kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ks = $urandom_range(0, 2);
      start_job(kr, ks); wait_events;
      sweep(10 + 2 * ks);
      if ($urandom_range(0, 1) == 1) begin
        rk_addr = 4'($urandom_range(0, 10));
        illegal_start;
      end
    end

    start2 = 1'b1;
    key_size2 = 2'b10;
    push_chk(3, 129'd1);
    step;
    key_size2 = 2'b01;
    push_chk(3, 129'd1);
    step;
    key_size2 = 2'b00;
    push_chk(3, 129'd0);
    step;
    start2 = 1'b0;
    repeat (3) step;

    n_cmp++;
    if (ev_q.size() != 0 || chk_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pulses and %0d port checks left, required 0 and 0", ev_q.size(), chk_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: run still active at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
